dropout_sequencer: RTL and testbench

- Streams one OUT_SIZE_1-element activation vector, element by element, from dense layer 1 through the dropout stage into the next layer.
- Training mode: draws a keep/drop decision per element from an internal LFSR, zeroes dropped elements and rescales kept ones by 1/(1-p).
- Inference mode: passes data through unchanged.
- Sequences the vector with a start/done handshake and valid/ready on both streams.

---
 rtl/dropout_sequencer_pkg.sv | 44 ++++
 rtl/dropout_sequencer_if.sv | 37 +++
 rtl/dropout_sequencer_lfsr.sv | 31 +++
 rtl/dropout_sequencer.sv | 127 ++++++++++++
 tb/tb_dropout_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dropout_sequencer_pkg.sv
// Shared constants, FSM state type and the kept-element rescale helper for
// the dropout stage that sits between dense layer 1 and the next layer.
package nn_parameters;

  localparam int OUT_SIZE_1 = 128;
  localparam int VEC_LEN    = OUT_SIZE_1;
  localparam int DATA_W     = 24;
  localparam int IDX_W      = 7;
  localparam int PROD_W     = 40;

  localparam logic [7:0]  DROP_THRESH  = 8'd51;
  localparam logic [15:0] KEEP_SCALE   = 16'd320;
  localparam logic [15:0] SEED_DEFAULT = 16'hACE1;
  // Feedback taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;

  localparam logic signed [PROD_W-1:0] SAT_MAX = (PROD_W'(1) <<< (DATA_W - 1)) - PROD_W'(1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = -(PROD_W'(1) <<< (DATA_W - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } dropout_seq_state_t;

  // Q8.8 multiply, arithmetic shift (floor) and clamp to the element range.
  function automatic logic [DATA_W-1:0] keep_rescale(input logic signed [DATA_W-1:0] x);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] k;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shr;
    logic [DATA_W-1:0]        res;
    a    = $signed({{(PROD_W - DATA_W){x[DATA_W-1]}}, x});
    k    = $signed({{(PROD_W - 16){1'b0}}, KEEP_SCALE});
    prod = a * k;
    shr  = prod >>> 8;
    if (shr > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
    else if (shr < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
    else                    res = shr[DATA_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/dropout_sequencer_if.sv
// Control and stream bundle of the dropout sequencer, plus read-only debug
// visibility of FSM state and LFSR contents.
interface dropout_sequencer_if;
  import nn_parameters::*;

  // Both streams: a beat transfers on a clock edge where valid && ready;
  // a producer holding valid keeps its payload stable until that edge.
  logic                 start;
  logic                 train_en;
  logic                 seed_load;
  logic [15:0]          seed;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [IDX_W-1:0]     out_index;
  logic                 out_dropped;
  logic                 busy;
  logic                 done;
  dropout_seq_state_t   dbg_state;
  logic [15:0]          dbg_lfsr;

  modport master (
    output start, train_en, seed_load, seed, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_dropped, busy, done,
           dbg_state, dbg_lfsr
  );

  modport slave (
    input  start, train_en, seed_load, seed, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_dropped, busy, done,
           dbg_state, dbg_lfsr
  );

endinterface

// File: rtl/dropout_sequencer_lfsr.sv
// 16-bit Fibonacci LFSR (left shift, feedback into bit 0) with a load port
// that substitutes the default seed for an all-zero seed.
module dropout_lfsr
  import nn_parameters::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        adv,
  output logic [15:0] value
);

  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb  = ^(r_lfsr & LFSR_TAPS);
  assign value = r_lfsr;

  // Load wins over advance; zero is a lock-up state so it is never stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED_DEFAULT;
    end else if (load) begin
      r_lfsr <= (seed == 16'd0) ? SEED_DEFAULT : seed;
    end else if (adv) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

endmodule

// File: rtl/dropout_sequencer.sv
// Streams one activation vector through dropout: LFSR keep/drop with 1.25x
// rescale in training mode, plain pass-through in inference mode.
module dropout_sequencer
  import nn_parameters::*;
(
  input  logic                clk,
  input  logic                rst,
  dropout_sequencer_if.slave  bus
);

  dropout_seq_state_t r_state;
  dropout_seq_state_t w_state_nxt;

  logic [IDX_W-1:0]  r_count;
  logic              r_mode;
  logic              r_out_valid;
  logic              r_out_dropped;
  logic [DATA_W-1:0] r_out_data;
  logic [IDX_W-1:0]  r_out_index;

  logic              w_in_ready;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_last;
  logic              w_idle_start;
  logic              w_lfsr_load;
  logic              w_lfsr_adv;
  logic              w_drop;
  logic [15:0]       w_lfsr;
  logic [DATA_W-1:0] w_elem;

  assign w_last       = (r_count == IDX_W'(VEC_LEN - 1));
  assign w_in_fire    = bus.in_valid && w_in_ready;
  assign w_out_fire   = r_out_valid && bus.out_ready;
  assign w_idle_start = (r_state == S_IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Single output register: accept whenever it is empty or draining this cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        w_in_ready = !r_out_valid || bus.out_ready;
        if (bus.in_valid && w_in_ready && w_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_out_valid && bus.out_ready) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // The decision uses the LFSR value before this element's advance.
  assign w_lfsr_load = (r_state == S_IDLE) && bus.seed_load;
  assign w_lfsr_adv  = w_in_fire && r_mode;
  assign w_drop      = r_mode && (w_lfsr[7:0] < DROP_THRESH);

  always_comb begin
    w_elem = bus.in_data;
    if (r_mode) begin
      w_elem = w_drop ? '0 : keep_rescale($signed(bus.in_data));
    end
  end

  dropout_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (w_lfsr_load),
    .seed  (bus.seed),
    .adv   (w_lfsr_adv),
    .value (w_lfsr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count       <= '0;
      r_mode        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_dropped <= 1'b0;
      r_out_data    <= '0;
      r_out_index   <= '0;
    end else begin
      if (w_idle_start) begin
        r_mode  <= bus.train_en;
        r_count <= '0;
      end else if (w_in_fire) begin
        r_count <= r_count + 1'b1;
      end

      if (w_in_fire) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_elem;
        r_out_index   <= r_count;
        r_out_dropped <= w_drop;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_index   = r_out_index;
  assign bus.out_dropped = r_out_dropped;
  assign bus.busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign bus.done        = (r_state == S_DONE);
  assign bus.dbg_state   = r_state;
  assign bus.dbg_lfsr    = w_lfsr;

endmodule

// File: tb/tb_dropout_sequencer.sv
// Bench for dropout_sequencer: vector-level reference model with an expected
// queue, arithmetic table on kept elements, and multi-cycle corner sequences.
module tb_dropout_sequencer;
  import nn_parameters::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dropout_sequencer_if bus();

  dropout_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_lfsr = 16'hACE1;
  bit          m_mode = 1'b0;
  int          m_idx  = 0;
  int          m_drops = 0;
  logic [31:0] exp_q[$];
  int          in_vec[128];

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // x * 1.25 rounded toward -inf, clamped to the signed 24-bit range.
  function automatic logic [23:0] rescale_ref(input int x);
    longint p;
    longint q;
    p = longint'(x) * 320;
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    if (q > 8388607)  q = 8388607;
    if (q < -8388608) q = -8388608;
    return 24'(q);
  endfunction

  task automatic model_accept(input int x);
    logic [23:0] d;
    bit          dr;
    dr = 1'b0;
    d  = 24'(x);
    if (m_mode) begin
      dr     = (m_lfsr[7:0] < 8'd51);
      d      = dr ? 24'd0 : rescale_ref(x);
      m_lfsr = lfsr_next(m_lfsr);
    end
    if (dr) m_drops++;
    exp_q.push_back({dr, 7'(m_idx), d});
    m_idx++;
  endtask

  // ---------------- output monitor / scoreboard ----------------
  int          cyc       = 0;
  int          last_fire = -100;
  int          done_cnt  = 0;
  int          got_drops = 0;
  logic [31:0] got_word[128];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_word  = '0;
  logic [31:0] mon_word;
  logic [31:0] exp_word;

  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      mon_word = {bus.out_dropped, bus.out_index, bus.out_data};
      if (prev_stall) check("stall_hold", {bus.out_valid, mon_word}, {1'b1, prev_word});
      if (bus.out_valid && !bus.out_ready) check("stall_in_ready", 64'(bus.in_ready), 64'd0);
      if (bus.out_valid && bus.out_ready) begin
        check("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check("out_elem", 64'(mon_word), 64'(exp_word));
        end
        got_word[bus.out_index] = mon_word;
        if (bus.out_dropped) got_drops++;
        last_fire = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        check("done_timing", 64'(cyc), 64'(last_fire + 1));
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = mon_word;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    bus.start = 1'b0; bus.seed_load = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("rst_outputs",
          64'({bus.in_ready, bus.out_valid, bus.out_dropped, bus.busy, bus.done,
               bus.out_data, bus.out_index}), 64'd0);
    check("rst_lfsr", 64'(bus.dbg_lfsr), 64'h0000_0000_0000_ACE1);
    check("rst_state", 64'(bus.dbg_state), 64'(S_IDLE));
    exp_q.delete();
    m_lfsr = 16'hACE1; m_mode = 1'b0; m_idx = 0;
    last_fire = -100;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic load_seed(input logic [15:0] s);
    @(posedge clk); #1;
    bus.seed_load = 1'b1; bus.seed = s;
    m_lfsr = (s == 16'd0) ? 16'hACE1 : s;
    @(posedge clk); #1;
    bus.seed_load = 1'b0; bus.seed = 16'($urandom);
    check("seed_loaded", 64'(bus.dbg_lfsr), 64'(m_lfsr));
  endtask

  task automatic begin_vec(input bit train, input bit do_seed, input logic [15:0] s);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.train_en = train; bus.seed_load = do_seed; bus.seed = s;
    if (do_seed) m_lfsr = (s == 16'd0) ? 16'hACE1 : s;
    m_mode = train; m_idx = 0; m_drops = 0; got_drops = 0;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.seed_load = 1'b0; bus.train_en = 1'($urandom_range(0, 1));
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic stream(input bit rand_ready, input bit gaps, input int start_at,
                        input int abort_at, output int n_sent);
    int sent = 0;
    int c    = 0;
    int d0   = done_cnt;
    while (c < 4000) begin
      if (abort_at >= 0 && sent >= abort_at) break;
      if (sent >= 128 && done_cnt != d0) break;
      @(posedge clk); #1;
      bus.start     = (c == start_at);
      bus.in_valid  = (sent < 128) && (!gaps || $urandom_range(0, 3) != 0);
      bus.in_data   = 24'(in_vec[(sent < 128) ? sent : 127]);
      bus.out_ready = !rand_ready || ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        model_accept(in_vec[sent]);
        sent++;
      end
      c++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    n_sent = sent;
  endtask

  task automatic finish_vec(input int d0, input string tag);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_one_done"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_idle"}, 64'(bus.dbg_state), 64'(S_IDLE));
    check({tag, "_lfsr"}, 64'(bus.dbg_lfsr), 64'(m_lfsr));
  endtask

  typedef struct {
    int          k;
    int          din;
    logic [23:0] dout;
  } arith_vec_t;

  arith_vec_t tbl[12];
  int         kept[$];

  initial begin
    int          n;
    int          d0;
    logic [15:0] v;
    logic [15:0] rs;

    bus.start = 1'b0; bus.train_en = 1'b0; bus.seed_load = 1'b0; bus.seed = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;

    apply_reset();

    // Bypass: ramp -64..63, LFSR must not move.
    for (int i = 0; i < 128; i++) in_vec[i] = i - 64;
    d0 = done_cnt;
    begin_vec(1'b0, 1'b0, 16'h0);
    stream(1'b0, 1'b0, -1, -1, n);
    finish_vec(d0, "bypass");
    check("bypass_lfsr_default", 64'(bus.dbg_lfsr), 64'h0000_0000_0000_ACE1);
    check("bypass_no_drops", 64'(got_drops), 64'd0);

    // Train scaling with the default seed, constant 1000 input.
    load_seed(16'hACE1);
    for (int i = 0; i < 128; i++) in_vec[i] = 1000;
    d0 = done_cnt;
    begin_vec(1'b1, 1'b0, 16'h0);
    stream(1'b0, 1'b0, -1, -1, n);
    finish_vec(d0, "train");
    check("train_drop_count", 64'(got_drops), 64'(m_drops));

    // Arithmetic table placed on kept indices of seed 0x1234.
    tbl[0]  = '{0,  8388607,  24'h7FFFFF};
    tbl[1]  = '{1,  -8388608, 24'h800000};
    tbl[2]  = '{2,  -3,       24'hFFFFFC};
    tbl[3]  = '{3,  1000,     24'd1250};
    tbl[4]  = '{4,  -1000,    24'hFFFB1E};
    tbl[5]  = '{5,  6710886,  24'h7FFFFF};
    tbl[6]  = '{6,  6710887,  24'h7FFFFF};
    tbl[7]  = '{7,  -6710886, 24'h800000};
    tbl[8]  = '{8,  -2,       24'hFFFFFD};
    tbl[9]  = '{9,  2,        24'd2};
    tbl[10] = '{10, 1,        24'd1};
    tbl[11] = '{11, -1,       24'hFFFFFE};
    kept.delete();
    v = 16'h1234;
    for (int i = 0; i < 128; i++) begin
      if (v[7:0] >= 8'd51) kept.push_back(i);
      v = lfsr_next(v);
    end
    for (int i = 0; i < 128; i++) in_vec[i] = int'($urandom_range(0, 16777215)) - 8388608;
    for (int t = 0; t < 12; t++) in_vec[kept[tbl[t].k]] = tbl[t].din;
    d0 = done_cnt;
    begin_vec(1'b1, 1'b1, 16'h1234);
    stream(1'b0, 1'b1, -1, -1, n);
    finish_vec(d0, "sat");
    for (int t = 0; t < 12; t++) begin
      check($sformatf("arith_%0d", tbl[t].din),
            64'({got_word[kept[tbl[t].k]][31], got_word[kept[tbl[t].k]][23:0]}),
            64'({1'b0, tbl[t].dout}));
    end

    // Backpressure with random data, random gaps, seed loaded with start.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 128; i++) in_vec[i] = int'($urandom_range(0, 16777215)) - 8388608;
      rs = 16'($urandom);
      d0 = done_cnt;
      begin_vec(1'(r), 1'b1, rs);
      stream(1'b1, 1'b1, -1, -1, n);
      finish_vec(d0, "bp");
    end

    // Zero seed falls back to default; a start during RUN is ignored.
    load_seed(16'h5555);
    load_seed(16'h0000);
    check("zero_seed_default", 64'(bus.dbg_lfsr), 64'h0000_0000_0000_ACE1);
    for (int i = 0; i < 128; i++) in_vec[i] = int'($urandom_range(0, 4000)) - 2000;
    d0 = done_cnt;
    begin_vec(1'b1, 1'b0, 16'h0);
    stream(1'b1, 1'b0, 20, -1, n);
    finish_vec(d0, "start_ignored");

    // Mid-vector reset after 40 accepts: no done, then a clean new vector.
    for (int i = 0; i < 128; i++) in_vec[i] = int'($urandom_range(0, 16777215)) - 8388608;
    d0 = done_cnt;
    begin_vec(1'b1, 1'b1, 16'hBEEF);
    stream(1'b1, 1'b0, -1, 40, n);
    check("abort_accepts", 64'(n), 64'd40);
    apply_reset();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    d0 = done_cnt;
    begin_vec(1'b0, 1'b0, 16'h0);
    stream(1'b1, 1'b1, -1, -1, n);
    finish_vec(d0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
